// File: rtl/stream_stim_monitor_pkg.sv
// Shared types and helpers for the stream stimulus/measurement harness:
// phase encoding, LFSR polynomial and step function, saturating increment.
package stream_stim_pkg;

  typedef enum logic [1:0] {
    PH_RESET  = 2'd0,
    PH_CONFIG = 2'd1,
    PH_RUN    = 2'd2,
    PH_DONE   = 2'd3
  } phase_t;

  localparam logic [31:0] LFSR_POLY = 32'h80200003;

  // Galois right-shift step; bit 0 feeds back through the polynomial taps.
  function automatic logic [31:0] lfsr_next(input logic [31:0] s);
    return (s >> 1) ^ (s[0] ? LFSR_POLY : 32'h0);
  endfunction

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  // An all-zero LFSR state would lock up, so it is replaced by 1.
  function automatic logic [31:0] seed_fix(input logic [31:0] s);
    return (s == 32'h0) ? 32'h1 : s;
  endfunction

endpackage

// File: rtl/stream_stim_monitor_if.sv
// Bundle between the harness (master) and the application DUT (slave):
// pull-style input channels plus the DUT's output stream.
interface stream_stim_monitor_if #(
  parameter int NCH   = 1,
  parameter int WIDTH = 16
);
  // read_en[c] pulls one word: the DUT consumes read_data[c] in the cycle it
  // raises read_en[c], and the next word appears after the following edge.
  // The output stream has no ready: every cycle with out_valid=1 is a beat.
  logic [NCH-1:0]            read_en;
  logic [NCH-1:0][WIDTH-1:0] read_data;
  logic                      out_valid;
  logic [WIDTH-1:0]          out_data;

  modport master (input read_en, output read_data, input out_valid, input out_data);
  modport slave  (output read_en, input read_data, output out_valid, output out_data);
endinterface

// File: rtl/stream_stim_monitor_stim_lfsr.sv
// Single-channel stimulus source: 32-bit Galois LFSR that steps only when
// the consumer pulls, exposing the low WIDTH bits (zero-extended if wider).
module stim_lfsr
  import stream_stim_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      seed,
  input  logic             advance,
  output logic [WIDTH-1:0] data
);

  logic [31:0] state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= seed_fix(seed);
    end else if (advance) begin
      state <= lfsr_next(state);
    end
  end

  generate
    if (WIDTH <= 32) begin : g_narrow
      assign data = state[WIDTH-1:0];
    end else begin : g_wide
      assign data = {{(WIDTH-32){1'b0}}, state};
    end
  endgenerate

endmodule

// File: rtl/stream_stim_monitor.sv
// Stimulus-and-measurement harness: RESET->CONFIG->RUN->DONE window with beat
// count and checksum. Define STIM_TOGGLE_COUNT_EN to build the input toggle counter.
module stream_stim_monitor
  import stream_stim_pkg::*;
#(
  parameter int          NCH           = 1,
  parameter int          WIDTH         = 16,
  parameter int          CONFIG_CYCLES = 409,
  parameter int          RUN_CYCLES    = 1000,
  parameter logic [31:0] SEED          = 32'h1
) (
  input  logic                  clk,
  input  logic                  rst,
  stream_stim_monitor_if.master bus,
  output logic                  measure_active,
  output logic                  window_start,
  output logic                  window_stop,
  output logic                  done,
  output logic [31:0]           beat_count,
  output logic [31:0]           checksum,
  output logic [31:0]           toggle_count,
  output phase_t                phase
);

  localparam logic [31:0] CFG_LAST = (CONFIG_CYCLES == 0) ? 32'd0 : 32'(CONFIG_CYCLES - 1);
  localparam logic [31:0] RUN_LAST = 32'(RUN_CYCLES - 1);
  localparam int          DW       = (WIDTH < 32) ? WIDTH : 32;

  phase_t      state, state_next;
  logic [31:0] cnt, cnt_next;
  logic [31:0] data_ext;

  for (genvar c = 0; c < NCH; c++) begin : g_ch
    stim_lfsr #(.WIDTH(WIDTH)) u_lfsr (
      .clk     (clk),
      .rst     (rst),
      .seed    (SEED + 32'(c)),
      .advance (bus.read_en[c]),
      .data    (bus.read_data[c])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= PH_RESET;
      cnt   <= 32'd0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    case (state)
      PH_RESET: begin
        cnt_next   = 32'd0;
        state_next = (CONFIG_CYCLES == 0) ? PH_RUN : PH_CONFIG;
      end
      PH_CONFIG: begin
        if (cnt == CFG_LAST) begin
          state_next = PH_RUN;
          cnt_next   = 32'd0;
        end else begin
          cnt_next = cnt + 32'd1;
        end
      end
      PH_RUN: begin
        if (cnt == RUN_LAST) begin
          state_next = PH_DONE;
          cnt_next   = 32'd0;
        end else begin
          cnt_next = cnt + 32'd1;
        end
      end
      default: begin
        state_next = PH_DONE;
      end
    endcase
  end

  assign phase = state;

  // Flags are registered from the next state so they line up with the phase.
  always_ff @(posedge clk) begin
    if (rst) begin
      measure_active <= 1'b0;
      window_start   <= 1'b0;
      window_stop    <= 1'b0;
      done           <= 1'b0;
    end else begin
      measure_active <= (state_next == PH_RUN);
      window_start   <= (state_next == PH_RUN) && (state != PH_RUN);
      window_stop    <= (state_next == PH_DONE) && (state != PH_DONE);
      done           <= (state_next == PH_DONE);
    end
  end

  always_comb begin
    data_ext         = 32'd0;
    data_ext[DW-1:0] = bus.out_data[DW-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      beat_count <= 32'd0;
      checksum   <= 32'd0;
    end else if (measure_active && bus.out_valid) begin
      beat_count <= sat_inc(beat_count);
      checksum   <= {checksum[30:0], checksum[31]} ^ data_ext;
    end
  end

`ifdef STIM_TOGGLE_COUNT_EN
  logic [NCH-1:0][WIDTH-1:0] prev_q;
  logic [NCH-1:0][WIDTH-1:0] diff;
  logic [31:0]               pop;
  logic [32:0]               tog_sum;

  // prev_q needs no reset: RUN is always preceded by at least one cycle in
  // RESET, which reloads it with the seed data before it is ever counted.
  always_ff @(posedge clk) begin
    prev_q <= bus.read_data;
  end

  always_comb begin
    diff = bus.read_data ^ prev_q;
    pop  = 32'd0;
    for (int c = 0; c < NCH; c++) begin
      for (int b = 0; b < WIDTH; b++) begin
        pop = pop + {31'd0, diff[c][b]};
      end
    end
    tog_sum = {1'b0, toggle_count} + {1'b0, pop};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      toggle_count <= 32'd0;
    end else if (measure_active) begin
      toggle_count <= tog_sum[32] ? 32'hFFFF_FFFF : tog_sum[31:0];
    end
  end
`else
  assign toggle_count = 32'd0;
`endif

endmodule

// File: tb/tb_stream_stim_monitor.sv
// Randomised bench for stream_stim_monitor: two instances (CONFIG 4 / RUN 6 and
// CONFIG 0 / RUN 3) share stimulus and are scored against a cycle-indexed model.
module tb_stream_stim_monitor;
  import stream_stim_pkg::*;

  localparam int          NCH   = 2;
  localparam int          WIDTH = 16;
  localparam int          CA    = 4;
  localparam int          RA    = 6;
  localparam int          CB    = 0;
  localparam int          RB    = 3;
  localparam logic [31:0] SEED  = 32'h1;

  logic clk = 1'b0;
  logic rst = 1'b1;

  stream_stim_monitor_if #(.NCH(NCH), .WIDTH(WIDTH)) bus_a ();
  stream_stim_monitor_if #(.NCH(NCH), .WIDTH(WIDTH)) bus_b ();

  logic        ma_a, ws_a, wp_a, dn_a, ma_b, ws_b, wp_b, dn_b;
  logic [31:0] beats_a, csum_a, tog_a, beats_b, csum_b, tog_b;
  phase_t      ph_a, ph_b;

  stream_stim_monitor #(.NCH(NCH), .WIDTH(WIDTH), .CONFIG_CYCLES(CA), .RUN_CYCLES(RA), .SEED(SEED)) dut_a (
    .clk(clk), .rst(rst), .bus(bus_a), .measure_active(ma_a), .window_start(ws_a),
    .window_stop(wp_a), .done(dn_a), .beat_count(beats_a), .checksum(csum_a),
    .toggle_count(tog_a), .phase(ph_a)
  );

  stream_stim_monitor #(.NCH(NCH), .WIDTH(WIDTH), .CONFIG_CYCLES(CB), .RUN_CYCLES(RB), .SEED(SEED)) dut_b (
    .clk(clk), .rst(rst), .bus(bus_b), .measure_active(ma_b), .window_start(ws_b),
    .window_stop(wp_b), .done(dn_b), .beat_count(beats_b), .checksum(csum_b),
    .toggle_count(tog_b), .phase(ph_b)
  );

  // clock/reset
  always #5 clk = ~clk;

  typedef struct packed {
    logic [NCH-1:0][WIDTH-1:0] rd;
    logic [1:0][5:0]           fl;   // {phase, measure_active, window_start, window_stop, done}
    logic [1:0][31:0]          beats;
    logic [1:0][31:0]          csum;
    logic [1:0][31:0]          tog;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // reference model state
  int                        k = 0;
  logic [31:0]               ls[NCH];
  logic [NCH-1:0][WIDTH-1:0] rd_prev;
  logic [31:0]               m_beats[2];
  logic [31:0]               m_csum[2];
  logic [31:0]               m_tog[2];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    return (s >> 1) ^ (s[0] ? 32'h80200003 : 32'h0);
  endfunction

  function automatic logic [31:0] seed_of(input int c);
    logic [31:0] s;
    s = SEED + 32'(c);
    return (s == 32'h0) ? 32'h1 : s;
  endfunction

  function automatic logic [NCH-1:0][WIDTH-1:0] rd_now();
    logic [NCH-1:0][WIDTH-1:0] r;
    for (int c = 0; c < NCH; c++) r[c] = ls[c][WIDTH-1:0];
    return r;
  endfunction

  function automatic logic [5:0] flags_at(input int kk, input int c, input int r);
    logic [1:0] ph;
    if (kk == 0) ph = 2'd0;
    else if (kk <= c) ph = 2'd1;
    else if (kk <= c + r) ph = 2'd2;
    else ph = 2'd3;
    return {ph, (kk >= c + 1 && kk <= c + r), (kk == c + 1), (kk == c + r + 1), (kk >= c + r + 1)};
  endfunction

  function automatic bit in_run(input int kk, input int i);
    int c, r;
    c = (i == 0) ? CA : CB;
    r = (i == 0) ? RA : RB;
    return (kk >= c + 1) && (kk <= c + r);
  endfunction

  // Advance the model across one clock edge given this cycle's inputs.
  task automatic model_edge(input logic r, input logic [NCH-1:0] en, input logic v, input logic [WIDTH-1:0] d);
    logic [NCH-1:0][WIDTH-1:0] cur;
    longint sum;
    cur = rd_now();
    if (r) begin
      k = 0;
      for (int c = 0; c < NCH; c++) ls[c] = seed_of(c);
      rd_prev = rd_now();
      for (int i = 0; i < 2; i++) begin
        m_beats[i] = 0; m_csum[i] = 0; m_tog[i] = 0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (in_run(k, i)) begin
          if (v) begin
            if (m_beats[i] != 32'hFFFF_FFFF) m_beats[i] = m_beats[i] + 1;
            m_csum[i] = {m_csum[i][30:0], m_csum[i][31]} ^ {16'h0, d};
          end
`ifdef STIM_TOGGLE_COUNT_EN
          sum = longint'(m_tog[i]) + longint'($countones(cur ^ rd_prev));
          m_tog[i] = (sum > 64'hFFFF_FFFF) ? 32'hFFFF_FFFF : sum[31:0];
`else
          sum = 0;
          m_tog[i] = sum[31:0];
`endif
        end
      end
      rd_prev = cur;
      for (int c = 0; c < NCH; c++) if (en[c]) ls[c] = lfsr_step(ls[c]);
      k++;
    end
  endtask

  // driver: drive at negedge, push the expected post-edge outputs, wait a cycle
  task automatic step(input logic r, input logic [NCH-1:0] en, input logic v, input logic [WIDTH-1:0] d);
    exp_t e;
    rst = r;
    bus_a.read_en = en;  bus_b.read_en = en;
    bus_a.out_valid = v; bus_b.out_valid = v;
    bus_a.out_data = d;  bus_b.out_data = d;
    model_edge(r, en, v, d);
    e.rd = rd_now();
    e.fl[0] = flags_at(k, CA, RA);
    e.fl[1] = flags_at(k, CB, RB);
    for (int i = 0; i < 2; i++) begin
      e.beats[i] = m_beats[i]; e.csum[i] = m_csum[i]; e.tog[i] = m_tog[i];
    end
    exp_q.push_back(e);
    @(negedge clk);
  endtask

  // monitor / scoreboard
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("read_data_a", 64'(bus_a.read_data), 64'(e.rd));
        chk("read_data_b", 64'(bus_b.read_data), 64'(e.rd));
        chk("flags_a", 64'({2'(ph_a), ma_a, ws_a, wp_a, dn_a}), 64'(e.fl[0]));
        chk("flags_b", 64'({2'(ph_b), ma_b, ws_b, wp_b, dn_b}), 64'(e.fl[1]));
        chk("beat_count_a", 64'(beats_a), 64'(e.beats[0]));
        chk("beat_count_b", 64'(beats_b), 64'(e.beats[1]));
        chk("checksum_a", 64'(csum_a), 64'(e.csum[0]));
        chk("checksum_b", 64'(csum_b), 64'(e.csum[1]));
        chk("toggle_count_a", 64'(tog_a), 64'(e.tog[0]));
        chk("toggle_count_b", 64'(tog_b), 64'(e.tog[1]));
      end
    end
  end

  initial begin
    bus_a.read_en = '0; bus_b.read_en = '0;
    bus_a.out_valid = 1'b0; bus_b.out_valid = 1'b0;
    bus_a.out_data = '0; bus_b.out_data = '0;
    @(negedge clk);

    // reset, then seeds must hold with no pulls
    step(1'b1, 2'b00, 1'b0, 16'h0);
    step(1'b1, 2'b00, 1'b0, 16'h0);
    chk("seed_hold", 64'(bus_a.read_data), 64'h0002_0001);

    // out_valid held with data 1; window positions and totals
    for (int i = 1; i <= 20; i++) begin
      step(1'b0, 2'b00, 1'b1, 16'h0001);
      chk("window_start_a_cycle", 64'(ws_a), 64'(i == 5));
      chk("window_start_b_cycle", 64'(ws_b), 64'(i == 1));
      chk("done_a_cycle", 64'(dn_a), 64'(i >= 11));
    end
    chk("beats_directed", 64'(beats_a), 64'd6);
    chk("checksum_directed", 64'(csum_a), 64'h3F);
    chk("seed_hold_late", 64'(bus_a.read_data), 64'h0002_0001);

    // single pulls
    step(1'b0, 2'b11, 1'b0, 16'h0);
    chk("pull_both", 64'(bus_a.read_data), 64'h0001_0003);
    step(1'b0, 2'b01, 1'b0, 16'h0);
    chk("pull_ch0", 64'(bus_a.read_data), 64'h0001_0002);

    // reset mid-RUN after three beats, then let the sequence repeat
    step(1'b1, 2'b00, 1'b0, 16'h0);
    for (int i = 1; i <= 8; i++) step(1'b0, 2'(i & 3), 1'b1, 16'(i * 7));
    chk("beats_before_reset", 64'(beats_a), 64'd3);
    step(1'b1, 2'b00, 1'b1, 16'h5);
    chk("reset_beats", 64'(beats_a), 64'd0);
    chk("reset_done", 64'({dn_a, ma_a}), 64'd0);
    chk("reset_seeds", 64'(bus_a.read_data), 64'h0002_0001);
    for (int i = 0; i < 15; i++) step(1'b0, 2'b11, 1'($urandom_range(0, 1)), 16'($urandom));

    // random traffic with occasional resets
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 39) == 0), 2'($urandom_range(0, 3)),
           1'($urandom_range(0, 1)), 16'($urandom));
    end
    step(1'b0, 2'b00, 1'b0, 16'h0);
    @(negedge clk);
    chk("queue_drained", 64'(exp_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
